reaction_timer: RTL and testbench

- Upstream stage of the reaction-test display path.
- Waits a pseudo-random delay after a start request, then lights the stimulus LED and counts elapsed milliseconds in 4-digit BCD until the player's hit.
- Then pulses det_end with the final count on ctrl[15:0], plus a restart pulse, for the downstream display stage.
- Runs on the 50 MHz system clock.

---
 rtl/reaction_pkg.sv | 21 ++
 rtl/bcd_cnt4.sv | 56 +++++
 rtl/reaction_timer.sv | 145 ++++++++++++++
 tb/tb_reaction_timer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_pkg.sv
// Shared types and constants for the reaction-test display path.
// Holds the FSM state encoding, BCD limits and the stimulus-delay LFSR helper.
package reaction_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        MEAS = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [15:0] BCD_MAX   = 16'h9999;
    localparam logic [15:0] FOUL_CODE = 16'hEEEE;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/bcd_cnt4.sv
// Four-digit BCD up-counter with synchronous clear and increment that
// saturates at 9999 instead of wrapping.
module bcd_cnt4 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] count
);
    import reaction_pkg::*;

    logic [15:0] count_r;
    logic [15:0] count_next_s;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Next-count selection: clear wins, then a non-saturated increment
    always_comb begin
        count_next_s = count_r;
        if (clr) begin
            count_next_s = 16'h0000;
        end else if (inc && (count_r != BCD_MAX)) begin
            count_next_s = bcd_inc(count_r);
        end else begin
            count_next_s = count_r;
        end
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= 16'h0000;
        end else begin
            count_r <= count_next_s;
        end
    end

    assign count = count_r;

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: random wait after start, then lights the LED and counts ms in BCD
// until hit. Define REACTION_FALSE_START_EN to report a hit during the wait as 16'hEEEE.
module reaction_timer #(
    parameter int unsigned TICK_DIV   = 50000,
    parameter int unsigned MIN_DLY_MS = 1000,
    parameter logic [15:0] RND_MASK   = 16'h07FF,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        hit,
    output logic        led,
    output logic        restart,
    output logic        det_end,
    output logic [15:0] ctrl
);
    import reaction_pkg::*;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    state_t        state_r;
    logic [TW-1:0] tick_cnt_r;
    logic [TW-1:0] tick_next_s;
    logic          tick_s;
    logic [15:0]   delay_r;
    logic [15:0]   lfsr_r;
    logic          led_r;
    logic          restart_r;
    logic          det_end_r;
    logic [15:0]   ctrl_r;
    logic          expire_s;
    logic          foul_s;
    logic          cnt_clr_s;
    logic          cnt_inc_s;
    logic [15:0]   count_s;

    assign tick_s      = (tick_cnt_r == TICK_LAST);
    assign tick_next_s = tick_s ? '0 : (tick_cnt_r + TW'(1));
    // A delay of 0 or 1 expires on the next tick, so a zero load cannot underflow
    assign expire_s    = (state_r == WAIT) && tick_s && (delay_r <= 16'd1);
`ifdef REACTION_FALSE_START_EN
    assign foul_s      = (state_r == WAIT) && hit;
`else
    assign foul_s      = 1'b0;
`endif

    // Counter control: clear on entry to MEAS, increment on ticks unless hit discards it
    always_comb begin
        cnt_clr_s = 1'b0;
        cnt_inc_s = 1'b0;
        if (state_r == WAIT) begin
            cnt_clr_s = expire_s && !foul_s;
        end else if (state_r == MEAS) begin
            cnt_inc_s = tick_s && !hit;
        end else begin
            cnt_clr_s = 1'b0;
        end
    end

    // LFSR free-runs in every state so the delay depends on when start arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= LFSR_SEED;
        end else begin
            lfsr_r <= lfsr_next(lfsr_r);
        end
    end

    // Trial FSM with tick divider, delay counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            tick_cnt_r <= '0;
            delay_r    <= 16'd0;
            led_r      <= 1'b0;
            restart_r  <= 1'b0;
            det_end_r  <= 1'b0;
            ctrl_r     <= 16'h0000;
        end else begin
            restart_r  <= 1'b0;
            det_end_r  <= 1'b0;
            tick_cnt_r <= tick_next_s;
            case (state_r)
                IDLE: begin
                    led_r <= 1'b0;
                    if (start) begin
                        state_r    <= WAIT;
                        restart_r  <= 1'b1;
                        delay_r    <= 16'(MIN_DLY_MS) + (lfsr_r & RND_MASK);
                        tick_cnt_r <= '0;
                    end
                end
                WAIT: begin
                    if (foul_s) begin
                        state_r    <= DONE;
                        det_end_r  <= 1'b1;
                        ctrl_r     <= FOUL_CODE;
                        tick_cnt_r <= '0;
                    end else if (expire_s) begin
                        state_r    <= MEAS;
                        led_r      <= 1'b1;
                        tick_cnt_r <= '0;
                    end else if (tick_s) begin
                        delay_r <= delay_r - 16'd1;
                    end
                end
                MEAS: begin
                    if (hit) begin
                        state_r    <= DONE;
                        led_r      <= 1'b0;
                        det_end_r  <= 1'b1;
                        ctrl_r     <= count_s;
                        tick_cnt_r <= '0;
                    end
                end
                DONE: begin
                    state_r    <= IDLE;
                    led_r      <= 1'b0;
                    tick_cnt_r <= '0;
                end
                default: begin
                    state_r    <= IDLE;
                    led_r      <= 1'b0;
                    tick_cnt_r <= '0;
                end
            endcase
        end
    end

    bcd_cnt4 u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr_s),
        .inc   (cnt_inc_s),
        .count (count_s)
    );

    assign led     = led_r;
    assign restart = restart_r;
    assign det_end = det_end_r;
    assign ctrl    = ctrl_r;

endmodule

// File: tb/tb_reaction_timer.sv
// Self-checking bench for reaction_timer: table of trials, hand-written corner
// sequences and random trials checked against a millisecond-level model.
module tb_reaction_timer;

    localparam int          T       = 3;
    localparam int          MIN_DLY = 5;
    localparam logic [15:0] MASK    = 16'h0003;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        hit = 1'b0;
    logic        led;
    logic        restart;
    logic        det_end;
    logic [15:0] ctrl;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] m_lfsr;
    logic [15:0] exp_ctrl = 16'h0000;

    typedef struct {
        string       name;
        int          hit_cyc;
        logic [15:0] exp;
        bit          wait_start;
        bit          meas_start;
        bit          done_start;
    } vec_t;

    vec_t vecs[7];

    reaction_timer #(
        .TICK_DIV   (T),
        .MIN_DLY_MS (MIN_DLY),
        .RND_MASK   (MASK),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .hit     (hit),
        .led     (led),
        .restart (restart),
        .det_end (det_end),
        .ctrl    (ctrl)
    );

    always #5 clk = ~clk;

    // Reference LFSR: 16-bit Fibonacci, taps 16,14,13,11, stepping every clock
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= SEED;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [15:0] to_bcd(input int ms);
        int v;
        v = (ms > 9999) ? 9999 : ms;
        return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observe WAIT until led rises; k counts observations since the start cycle
    task automatic wait_led(input string name, input int k_in, input int d_exp, input bit wait_start);
        int k;
        bit bad;
        k   = k_in;
        bad = 1'b0;
        while (!led && k < 200) begin
            if (wait_start && k == 2) start = 1'b1;
            step();
            start = 1'b0;
            k++;
            if (restart || det_end || ctrl !== exp_ctrl) bad = 1'b1;
        end
        chk({name, "/led_rise"}, k, 1 + d_exp * T);
        chk({name, "/wait_quiet"}, bad, 0);
    endtask

    // Measure for hit_cyc cycles after led rose, hit, then check the result pulse
    task automatic finish_meas(input string name, input int hit_cyc, input logic [15:0] exp,
                               input bit meas_start, input bit done_start);
        bit bad;
        bad = 1'b0;
        for (int c = 0; c < hit_cyc; c++) begin
            if (meas_start && c == 5) start = 1'b1;
            step();
            start = 1'b0;
            if (!led || restart || det_end || ctrl !== exp_ctrl) bad = 1'b1;
        end
        chk({name, "/meas_quiet"}, bad, 0);
        hit = 1'b1;
        step();
        hit = 1'b0;
        chk({name, "/det_end"}, det_end, 1);
        chk({name, "/ctrl"}, ctrl, exp);
        chk({name, "/led_off"}, led, 0);
        exp_ctrl = exp;
        if (done_start) start = 1'b1;
        step();
        start = 1'b0;
        bad = det_end;
        for (int i = 0; i < 4; i++) begin
            if (restart || det_end || led || ctrl !== exp_ctrl) bad = 1'b1;
            step();
        end
        chk({name, "/after_quiet"}, bad, 0);
    endtask

    task automatic run_trial(input vec_t v);
        int d_exp;
        d_exp = MIN_DLY + int'(m_lfsr & MASK);
        start = 1'b1;
        step();
        start = 1'b0;
        chk({v.name, "/restart"}, restart, 1);
        wait_led(v.name, 1, d_exp, v.wait_start);
        finish_meas(v.name, v.hit_cyc, v.exp, v.meas_start, v.done_start);
    endtask

    // Hit while waiting, either early or on the delay-expiry tick
    task automatic wait_hit(input string name, input bit at_expiry);
        int d_exp;
        int j;
        bit seen;
        d_exp = MIN_DLY + int'(m_lfsr & MASK);
        j     = at_expiry ? d_exp * T - 1 : 2;
        start = 1'b1;
        step();
        start = 1'b0;
        chk({name, "/restart"}, restart, 1);
        for (int i = 0; i < j; i++) step();
        hit = 1'b1;
        step();
        hit = 1'b0;
`ifdef REACTION_FALSE_START_EN
        chk({name, "/det_end"}, det_end, 1);
        chk({name, "/ctrl"}, ctrl, 16'hEEEE);
        chk({name, "/led_off"}, led, 0);
        exp_ctrl = 16'hEEEE;
        seen = 1'b0;
        for (int i = 0; i < d_exp * T + 10; i++) begin
            step();
            if (led || det_end || restart || ctrl !== exp_ctrl) seen = 1'b1;
        end
        chk({name, "/no_trial"}, seen, 0);
`else
        seen = det_end;
        chk({name, "/no_det_end"}, seen, 0);
        wait_led(name, j + 2, d_exp, 1'b0);
        finish_meas(name, 42 * T, 16'h0042, 1'b0, 1'b0);
`endif
    endtask

    initial begin
        vec_t rv;
        bit bad;
        vecs[0] = '{"t0",      0,           16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{"t123",    123 * T,     16'h0123, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{"t1000",   1000 * T,    16'h1000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"coinc99", 100 * T - 1, 16'h0099, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{"t10",     10 * T,      16'h0010, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{"coinc9",  10 * T - 1,  16'h0009, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{"sat",     10050 * T,   16'h9999, 1'b0, 1'b0, 1'b0};

        // Reset
        step();
        step();
        chk("rst_hold/led", led, 0);
        rst_n = 1'b1;
        step();
        chk("rst/led", led, 0);
        chk("rst/det_end", det_end, 0);
        chk("rst/restart", restart, 0);
        chk("rst/ctrl", ctrl, 16'h0000);

        // Hits in IDLE are ignored
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            hit = (i % 2 == 0);
            step();
            if (det_end || restart || led || ctrl !== exp_ctrl) bad = 1'b1;
        end
        hit = 1'b0;
        chk("idle_hit/quiet", bad, 0);

        foreach (vecs[i]) begin
            run_trial(vecs[i]);
            for (int g = 0; g < i + 1; g++) step();
        end

        wait_hit("wait_hit_early", 1'b0);
        step();
        wait_hit("wait_hit_expiry", 1'b1);
        step();

        // Reset in the middle of a measurement at count 0050
        rv = '{"pre_rst", 0, 16'h0000, 1'b0, 1'b0, 1'b0};
        begin
            int d_exp;
            d_exp = MIN_DLY + int'(m_lfsr & MASK);
            start = 1'b1;
            step();
            start = 1'b0;
            wait_led("mid_rst", 1, d_exp, 1'b0);
            for (int c = 0; c < 50 * T; c++) step();
            #2 rst_n = 1'b0;
            #1;
            chk("mid_rst/led", led, 0);
            chk("mid_rst/ctrl", ctrl, 16'h0000);
            chk("mid_rst/det_end", det_end, 0);
            step();
            step();
            rst_n = 1'b1;
            exp_ctrl = 16'h0000;
            bad = 1'b0;
            for (int i = 0; i < 6; i++) begin
                step();
                if (det_end || restart || led || ctrl !== exp_ctrl) bad = 1'b1;
            end
            chk("mid_rst/quiet", bad, 0);
        end
        rv = '{"post_rst", 77 * T, 16'h0077, 1'b0, 1'b0, 1'b0};
        run_trial(rv);

        // Random trials against the millisecond model
        for (int r = 0; r < 6; r++) begin
            int gap;
            gap = $urandom_range(0, 20);
            for (int g = 0; g < gap; g++) step();
            rv.name       = $sformatf("rand%0d", r);
            rv.hit_cyc    = $urandom_range(0, 400);
            rv.exp        = to_bcd(rv.hit_cyc / T);
            rv.wait_start = 1'b0;
            rv.meas_start = 1'b0;
            rv.done_start = 1'b0;
            run_trial(rv);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
